// File: rtl/cam_pkg.sv
// Shared types and constants for the camera-to-FIFO capture path.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_VBLANK,
    ST_SKIP,
    ST_ACTIVE
  } cam_state_e;

  // RGB565 field positions
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_pixel_packer.sv
// Byte-pair packer: tracks hi/lo phase within a line and flags a dangling hi byte at line end.
module cam_pixel_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        active_i,
  input  logic        href_i,
  input  logic        line_end_i,
  input  logic [7:0]  data_i,
  output logic        pix_vld_o,
  output logic [15:0] pix_o,
  output logic        dangle_o
);

  // phase_q = 1 means the next byte is the low byte of a pixel
  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    if (clear_i || !href_i) begin
      phase_d = 1'b0;
    end else if (active_i) begin
      if (!phase_q) hi_d = data_i;
      phase_d = ~phase_q;
    end
  end

  assign pix_vld_o = active_i & href_i & phase_q;
  assign pix_o     = {hi_q, data_i};
  assign dangle_o  = line_end_i & phase_q;

endmodule

// File: rtl/cam_fifo_writer.sv
// DVP camera capture into the async FIFO write port, frame-aligned with geometry/overflow checks.
// Define CAM_TEST_PATTERN_EN to replace camera data with 8 vertical colour bars.
module cam_fifo_writer
  import cam_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        full_fifo,
  output logic        wr_en,
  output logic [15:0] dout,
  output logic        frame_start,
  output logic        frame_done,
  output logic        overflow,
  output logic        frame_err,
  output logic [7:0]  frame_cnt
);

  localparam int XW = $clog2(H_RES + 2);
  localparam int YW = $clog2(V_RES + 2);
  localparam int SW = $clog2(SKIP_FRAMES + 2);
  localparam logic [XW-1:0] X_END = XW'(H_RES);
  localparam logic [XW-1:0] X_SAT = XW'(H_RES + 1);
  localparam logic [YW-1:0] Y_END = YW'(V_RES);
  localparam logic [YW-1:0] Y_SAT = YW'(V_RES + 1);

  logic       vs_q, vs_qq, href_q, href_qq, en_q;
  logic [7:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      vs_qq   <= 1'b0;
      href_q  <= 1'b0;
      href_qq <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      vs_q    <= cam_vsync;
      vs_qq   <= vs_q;
      href_q  <= cam_href;
      href_qq <= href_q;
      data_q  <= cam_data;
      en_q    <= enable;
    end
  end

  logic vs_rise, vs_fall, line_end, active, clear;
  assign vs_rise  = vs_q & ~vs_qq;
  assign vs_fall  = ~vs_q & vs_qq;
  assign line_end = ~href_q & href_qq;

  cam_state_e    state_q, state_d;
  logic [SW-1:0] skip_q, skip_d, skip_cur;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          first_q, first_d, wr_en_q, wr_en_d, fs_q, fs_d, fd_q, fd_d;
  logic          ovf_q, ovf_d, err_q, err_d;
  logic [15:0]   dout_q, dout_d;
  logic [7:0]    cnt_q, cnt_d;

  assign active = (state_q == ST_ACTIVE);

  logic        pix_vld, dangle;
  logic [15:0] cam_pix, pix_out;

  cam_pixel_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .active_i   (active),
    .href_i     (href_q),
    .line_end_i (line_end),
    .data_i     (data_q),
    .pix_vld_o  (pix_vld),
    .pix_o      (cam_pix),
    .dangle_o   (dangle)
  );

`ifdef CAM_TEST_PATTERN_EN
  localparam int BAR_W = (H_RES / 8 < 1) ? 1 : H_RES / 8;
  logic [2:0] bar_idx;
  logic       unused_cam_pix;
  always_comb begin
    if (int'(x_q) / BAR_W > 7) bar_idx = 3'd7;
    else                       bar_idx = 3'(int'(x_q) / BAR_W);
  end
  assign pix_out        = bar_color(bar_idx);
  assign unused_cam_pix = ^cam_pix;
`else
  assign pix_out = cam_pix;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      skip_q  <= SW'(SKIP_FRAMES);
      x_q     <= '0;
      y_q     <= '0;
      first_q <= 1'b0;
      wr_en_q <= 1'b0;
      dout_q  <= '0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      x_q     <= x_d;
      y_q     <= y_d;
      first_q <= first_d;
      wr_en_q <= wr_en_d;
      dout_q  <= dout_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // an enable rise reloads the settling skip, wherever the FSM is
    skip_cur = (enable && !en_q) ? SW'(SKIP_FRAMES) : skip_q;
    state_d  = state_q;
    skip_d   = skip_cur;
    x_d      = x_q;
    y_d      = y_q;
    first_d  = first_q;
    wr_en_d  = 1'b0;
    dout_d   = dout_q;
    fs_d     = 1'b0;
    fd_d     = 1'b0;
    ovf_d    = ovf_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    clear    = 1'b0;
    case (state_q)
      ST_SYNC: if (vs_rise) state_d = ST_VBLANK;
      ST_VBLANK: begin
        if (vs_fall && enable) begin
          if (skip_cur != '0) begin
            skip_d  = skip_cur - 1'b1;
            state_d = ST_SKIP;
          end else begin
            state_d = ST_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            first_d = 1'b1;
            clear   = 1'b1;
          end
        end
      end
      ST_SKIP: if (vs_rise) state_d = ST_VBLANK;
      ST_ACTIVE: begin
        if (vs_rise) begin
          // vsync wins over a still-open line; that line is not counted
          fd_d    = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          if (y_q != Y_END || href_q) err_d = 1'b1;
          state_d = ST_VBLANK;
        end else begin
          if (pix_vld) begin
            if (full_fifo) begin
              ovf_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              dout_d  = pix_out;
              fs_d    = first_q;
              first_d = 1'b0;
            end
            if (x_q != X_SAT) x_d = x_q + 1'b1;
          end
          if (line_end) begin
            if (dangle || x_q != X_END) err_d = 1'b1;
            if (y_q != Y_SAT) y_d = y_q + 1'b1;
            x_d = '0;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign wr_en       = wr_en_q;
  assign dout        = dout_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign overflow    = ovf_q;
  assign frame_err   = err_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: doc/cam_fifo_writer.md
Name: cam_fifo_writer

Overview:
- Camera-side producer for the async FIFO drained by the VGA display path.
- Runs on the camera pixel clock and samples DVP-style signals: vsync, href and an 8-bit data bus carrying RGB565 as a high byte then a low byte.
- Packs each byte pair into one 16-bit pixel and writes it into the FIFO write port, frame-aligned, with overflow and geometry checking.
- The FIFO is never fed a partial frame after reset or resync.

Parameters:
- H_RES, 640, pixels per line expected.
- V_RES, 480, lines per frame expected.
- SKIP_FRAMES, 2, frames discarded after reset or enable rise (sensor settling); 0 means no skipping.

Ports:
- clk  in  1  camera pixel clock (PCLK); sole clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable, level.
- cam_vsync  in  1  frame sync, active high during vertical blank.
- cam_href  in  1  line valid, active high.
- cam_data  in  8  pixel byte bus.
- full_fifo  in  1  async FIFO full flag, write domain.
- wr_en  out  1  FIFO write strobe, one cycle per pixel.
- dout  out  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B.
- frame_start  out  1  pulse coincident with the first pixel's wr_en slot of a captured frame.
- frame_done  out  1  pulse, one cycle, at the end of a captured frame.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- frame_err  out  1  sticky: line length or line count did not match H_RES/V_RES.
- frame_cnt  out  8  captured frames, wraps 255->0.

Behaviour:
- Reset values: every output is 0; state SYNC; skip counter = SKIP_FRAMES; byte phase = high; x/y counters = 0.
- Input stage: cam_vsync, cam_href and cam_data are registered once. All decisions use the registered copies.
- Edge detection: vsync rise and fall are detected on the registered copy against a second delay register.
- State SYNC: wait for a vsync rise; then go to VBLANK. This guarantees no mid-frame start after reset.
- State VBLANK: on vsync fall:
  - if enable=0, stay in VBLANK;
  - else if skip counter != 0, decrement it and go to SKIP;
  - else go to ACTIVE, clearing x, y and byte phase.
- State SKIP: ignore data; on vsync rise go to VBLANK.
- State ACTIVE:
  - While href is registered high, bytes alternate high then low.
  - When the low byte is registered, the pixel {hi, lo} is formed.
  - wr_en and dout are registered and asserted one cycle after the low-byte register cycle. This is 2 clk edges after cam_data presents the low byte.
  - The first written pixel of the frame also pulses frame_start in the same cycle.
- href fall (line end):
  - Byte phase resets to high; a dangling high byte is discarded and sets frame_err.
  - If x != H_RES, set frame_err.
  - Then y++, x=0.
- vsync rise while in ACTIVE (frame end):
  - Pulse frame_done next cycle; frame_cnt++.
  - If y != V_RES, or href was still high, set frame_err.
  - Go to VBLANK.
- full_fifo high in a pixel slot:
  - No wr_en; pixel dropped; overflow=1.
  - x still increments, so geometry is unaffected.
- x saturates at H_RES+1 and y saturates at V_RES+1; no wrap, so an oversize line is still flagged.
- enable fall mid-frame: the current frame completes. The block then holds in VBLANK. enable re-rise reloads the skip counter to SKIP_FRAMES.
- Simultaneous vsync rise and href high: vsync takes priority. The line is not counted; frame_err is set.
- Clearing: overflow and frame_err clear only on rst_n.

Optional Feature:
- Macro: CAM_TEST_PATTERN_EN.
- Defined: cam_data is ignored. dout shows 8 vertical bars, each H_RES/8 pixels wide, selected from x: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. All timing, handshakes and checks are unchanged.
- Undefined: dout = {hi, lo} from the camera.

Decomposition:
- Shared package cam_pkg holds:
  - the state encoding (SYNC, VBLANK, SKIP, ACTIVE);
  - the RGB565 field positions;
  - the default H_RES/V_RES constants;
  - the colour-bar constants.
- One natural sub-module: cam_pixel_packer, covering byte phase, hi-byte hold, pixel-valid strobe and dangling-byte detection.

Test Plan:
- Reset, then 1 frame mid-stream, then 3 clean 4x2 frames (H_RES=4, V_RES=2, SKIP_FRAMES=2) -> no writes from the partial and skipped frames; third clean frame writes exactly 8 pixels; bytes 0xF8,0x1F -> dout=0xF81F; frame_cnt=1.
- Low byte presented at edge N -> wr_en high exactly after edge N+2; frame_start is set only with the first pixel.
- full_fifo=1 for pixel 3 of line 0 -> 7 writes; overflow=1; frame_err=0.
- Line with 7 bytes (H_RES=4) -> frame_err=1; the next line is packed correctly from its first byte.
- enable drops mid-frame -> frame finishes and frame_done pulses; no further writes until enable rises and 2 more frames are skipped.
- CAM_TEST_PATTERN_EN with H_RES=16 -> 8 bars of 2 pixels each; dout sequence FFFF,FFFF,FFE0,FFE0,…,0000.
